matrix_store: RTL and testbench

- Slot-based matrix register file that sits directly downstream of the random matrix generator and the user-input stage.
- Holds 4 matrix slots, each up to MAX_DIM x MAX_DIM elements of DATA_W bits, plus per-slot dimensions and a valid flag.
- Accepts the slot/row/col/data element-write interface and the dimension-write interface.
- Serves one registered read port to the compute and display stages, and provides a sequenced per-slot clear.

---
 rtl/matrix_store.sv | 249 ++++++++++++++++++++++++
 tb/tb_matrix_store.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_store.sv
`default_nettype none
// ============================================================================
// Module   : matrix_store
// Purpose  : Slot-based matrix register file. Four slots, each holding up to
//            MAX_DIM x MAX_DIM elements of DATA_W bits plus its dimensions
//            and a valid flag. Provides an element-write port, a dimension-
//            write port, one registered read port (latency 1), and a
//            sequenced per-slot clear that zeroes one element per cycle.
// Ports    :
//   clk, rst_n                       clock, asynchronous active-low reset
//   wr_slot/wr_row/wr_col/wr_data/wr_we   element write
//   dim_slot/dim_m/dim_n/dim_we           dimension write
//   rd_en/rd_slot/rd_row/rd_col           read request
//   rd_data/rd_valid/rd_dim_m/rd_dim_n    read result (one cycle later)
//   slot_valid                            per-slot "holds legal dims" flags
//   clr_start/clr_slot                    clear request
//   clr_busy/clr_done                     clear sweep status
//   err_wr                                rejected-write pulse
// Revision : 1.0  initial release
// ============================================================================
module matrix_store #(
    parameter int DATA_W  = 16,
    parameter int MAX_DIM = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        wr_slot,
    input  logic [2:0]        wr_row,
    input  logic [2:0]        wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_we,
    input  logic [1:0]        dim_slot,
    input  logic [2:0]        dim_m,
    input  logic [2:0]        dim_n,
    input  logic              dim_we,
    input  logic              rd_en,
    input  logic [1:0]        rd_slot,
    input  logic [2:0]        rd_row,
    input  logic [2:0]        rd_col,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [2:0]        rd_dim_m,
    output logic [2:0]        rd_dim_n,
    output logic [3:0]        slot_valid,
    input  logic              clr_start,
    input  logic [1:0]        clr_slot,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              err_wr
);

    localparam int          c_DEPTH   = MAX_DIM * MAX_DIM;
    localparam int          c_IDX_W   = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam logic [2:0]  c_MAX_DIM = 3'(MAX_DIM);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem [4][c_DEPTH];
    logic [2:0]         r_dim_m [4];
    logic [2:0]         r_dim_n [4];
    logic [3:0]         r_slot_valid;

    // Clear sequencer
    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_clr_slot;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_clr_done;
    logic               w_clr_go;
    logic               w_sweep;
    logic               w_last;

    // Read port registers
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_rd_valid;
    logic [2:0]         r_rd_dim_m;
    logic [2:0]         r_rd_dim_n;
    logic               r_err_wr;

    // ------------------------------------------------------------------------
    // Write qualification. All checks look at the dims registered before the
    // current edge, so a same-cycle dim write cannot widen an element write.
    // ------------------------------------------------------------------------
    logic               w_busy;
    logic               w_dim_legal;
    logic               w_dim_ok;
    logic               w_dim_rej;
    logic               w_wr_in_range;
    logic               w_wr_ok;
    logic               w_wr_rej;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic               w_rd_in_range;
    logic [c_IDX_W-1:0] w_rd_idx;

    assign w_busy      = (r_state == S_CLEAR);

    assign w_dim_legal = (dim_m != 3'd0) && (dim_m <= c_MAX_DIM) &&
                         (dim_n != 3'd0) && (dim_n <= c_MAX_DIM);
    assign w_dim_ok    = dim_we && w_dim_legal &&
                         !(w_busy && (dim_slot == r_clr_slot));
    assign w_dim_rej   = dim_we && !w_dim_ok;

    assign w_wr_in_range = r_slot_valid[wr_slot] &&
                           (wr_row < r_dim_m[wr_slot]) &&
                           (wr_col < r_dim_n[wr_slot]);
    assign w_wr_ok     = wr_we && w_wr_in_range &&
                         !(w_busy && (wr_slot == r_clr_slot));
    assign w_wr_rej    = wr_we && !w_wr_ok;

    // Index is only meaningful when the range check passes, where it is
    // always below c_DEPTH.
    assign w_wr_idx = c_IDX_W'(int'(wr_row) * MAX_DIM + int'(wr_col));
    assign w_rd_idx = c_IDX_W'(int'(rd_row) * MAX_DIM + int'(rd_col));

    assign w_rd_in_range = r_slot_valid[rd_slot] &&
                           (rd_row < r_dim_m[rd_slot]) &&
                           (rd_col < r_dim_n[rd_slot]);

    // ------------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_go    = 1'b0;
        w_sweep     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr_start) begin
                    w_clr_go    = 1'b1;
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_sweep = 1'b1;
                if (r_idx == c_LAST_IDX) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_slot <= 2'd0;
            r_idx      <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= w_sweep && w_last;
            if (w_clr_go) begin
                r_clr_slot <= clr_slot;
                r_idx      <= '0;
            end else if (w_sweep) begin
                r_idx      <= r_idx + c_IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Element and dimension storage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                for (int e = 0; e < c_DEPTH; e++) begin
                    r_mem[k][e] <= '0;
                end
                r_dim_m[k] <= 3'd0;
                r_dim_n[k] <= 3'd0;
            end
            r_slot_valid <= 4'b0000;
        end else begin
            // Element writes to the slot being swept are rejected above, so
            // these two writes never target the same location.
            if (w_wr_ok) begin
                r_mem[wr_slot][w_wr_idx] <= wr_data;
            end
            if (w_sweep) begin
                r_mem[r_clr_slot][r_idx] <= '0;
            end
            if (w_dim_ok) begin
                r_dim_m[dim_slot]      <= dim_m;
                r_dim_n[dim_slot]      <= dim_n;
                r_slot_valid[dim_slot] <= 1'b1;
            end
            // Starting a clear invalidates the slot immediately; placed last
            // so it overrides a same-cycle dimension write to that slot.
            if (w_clr_go) begin
                r_dim_m[clr_slot]      <= 3'd0;
                r_dim_n[clr_slot]      <= 3'd0;
                r_slot_valid[clr_slot] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read port and error pulse. Reads sample storage before this edge's
    // writes, giving read-before-write on address collisions.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_dim_m <= 3'd0;
            r_rd_dim_n <= 3'd0;
            r_err_wr   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_err_wr   <= w_dim_rej || w_wr_rej;
            if (rd_en) begin
                r_rd_dim_m <= r_dim_m[rd_slot];
                r_rd_dim_n <= r_dim_n[rd_slot];
                if (w_rd_in_range) begin
                    r_rd_data <= r_mem[rd_slot][w_rd_idx];
                end else begin
                    r_rd_data <= '0;
                end
            end
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign rd_dim_m   = r_rd_dim_m;
    assign rd_dim_n   = r_rd_dim_n;
    assign slot_valid = r_slot_valid;
    assign clr_busy   = w_busy;
    assign clr_done   = r_clr_done;
    assign err_wr     = r_err_wr;

endmodule
`default_nettype wire

// File: tb/tb_matrix_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_store
// Purpose  : Directed self-checking bench for matrix_store. Read results are
//            predicted into a scoreboard queue when the read is issued and
//            compared when the DUT returns them one cycle later.
// Revision : 1.0  initial release
// ============================================================================
module tb_matrix_store;

    localparam int DATA_W  = 16;
    localparam int MAX_DIM = 5;

    logic              clk;
    logic              rst_n;
    logic [1:0]        wr_slot;
    logic [2:0]        wr_row;
    logic [2:0]        wr_col;
    logic [DATA_W-1:0] wr_data;
    logic              wr_we;
    logic [1:0]        dim_slot;
    logic [2:0]        dim_m;
    logic [2:0]        dim_n;
    logic              dim_we;
    logic              rd_en;
    logic [1:0]        rd_slot;
    logic [2:0]        rd_row;
    logic [2:0]        rd_col;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [2:0]        rd_dim_m;
    logic [2:0]        rd_dim_n;
    logic [3:0]        slot_valid;
    logic              clr_start;
    logic [1:0]        clr_slot;
    logic              clr_busy;
    logic              clr_done;
    logic              err_wr;

    matrix_store #(
        .DATA_W  (DATA_W),
        .MAX_DIM (MAX_DIM)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_slot    (wr_slot),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .wr_we      (wr_we),
        .dim_slot   (dim_slot),
        .dim_m      (dim_m),
        .dim_n      (dim_n),
        .dim_we     (dim_we),
        .rd_en      (rd_en),
        .rd_slot    (rd_slot),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_dim_m   (rd_dim_m),
        .rd_dim_n   (rd_dim_n),
        .slot_valid (slot_valid),
        .clr_start  (clr_start),
        .clr_slot   (clr_slot),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .err_wr     (err_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [2:0]        m;
        logic [2:0]        n;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int errors   = 0;
    int err_cnt  = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (err_wr === 1'b1) err_cnt++;
    endtask

    task automatic dim_write(input logic [1:0] s, input logic [2:0] m,
                             input logic [2:0] n);
        dim_slot = s; dim_m = m; dim_n = n; dim_we = 1'b1;
        tick();
        dim_we = 1'b0;
    endtask

    task automatic el_write(input logic [1:0] s, input logic [2:0] r,
                            input logic [2:0] c, input logic [DATA_W-1:0] d);
        wr_slot = s; wr_row = r; wr_col = c; wr_data = d; wr_we = 1'b1;
        tick();
        wr_we = 1'b0;
    endtask

    // Pops the oldest prediction and compares it with the returned read.
    task automatic compare_read(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty observed=%0h", tag, rd_data);
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(rd_valid), 32'd1);
            check({tag, "_data"},  32'(rd_data),  32'(e.data));
            check({tag, "_dim_m"}, 32'(rd_dim_m), 32'(e.m));
            check({tag, "_dim_n"}, 32'(rd_dim_n), 32'(e.n));
        end
    endtask

    task automatic do_read(input string tag, input logic [1:0] s,
                           input logic [2:0] r, input logic [2:0] c,
                           input logic [DATA_W-1:0] d,
                           input logic [2:0] m, input logic [2:0] n);
        rd_slot = s; rd_row = r; rd_col = c; rd_en = 1'b1;
        sb.push_back('{data: d, m: m, n: n});
        tick();
        rd_en = 1'b0;
        compare_read(tag);
    endtask

    initial begin
        int err_base;
        rst_n = 1'b0;
        wr_slot = '0; wr_row = '0; wr_col = '0; wr_data = '0; wr_we = 1'b0;
        dim_slot = '0; dim_m = '0; dim_n = '0; dim_we = 1'b0;
        rd_en = 1'b0; rd_slot = '0; rd_row = '0; rd_col = '0;
        clr_start = 1'b0; clr_slot = '0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_slot_valid", 32'(slot_valid), 32'h0);
        check("rst_rd_valid",   32'(rd_valid),   32'h0);
        check("rst_rd_data",    32'(rd_data),    32'h0);
        check("rst_clr_busy",   32'(clr_busy),   32'h0);
        check("rst_clr_done",   32'(clr_done),   32'h0);
        check("rst_err_wr",     32'(err_wr),     32'h0);
        rst_n = 1'b1;
        tick();

        do_read("rd_empty", 2'd0, 3'd0, 3'd0, 16'h0, 3'd0, 3'd0);
        tick();
        check("rd_valid_pulse", 32'(rd_valid), 32'h0);

        // ---------------- basic write / read ----------------
        err_cnt = 0;
        dim_write(2'd2, 3'd3, 3'd4);
        el_write(2'd2, 3'd2, 3'd3, 16'h00A5);
        check("slot_valid_2", 32'(slot_valid), 32'h4);
        do_read("rd_s2_23", 2'd2, 3'd2, 3'd3, 16'h00A5, 3'd3, 3'd4);
        check("no_err_basic", 32'(err_cnt), 32'd0);

        // ---------------- range violations ----------------
        el_write(2'd2, 3'd3, 3'd0, 16'h1111);
        el_write(2'd2, 3'd0, 3'd4, 16'h2222);
        check("err_oob_writes", 32'(err_cnt), 32'd2);
        do_read("rd_s2_30", 2'd2, 3'd3, 3'd0, 16'h0, 3'd3, 3'd4);
        do_read("rd_s2_04", 2'd2, 3'd0, 3'd4, 16'h0, 3'd3, 3'd4);
        dim_write(2'd2, 3'd6, 3'd2);
        check("err_bad_dim", 32'(err_cnt), 32'd3);
        dim_write(2'd2, 3'd0, 3'd2);
        check("err_zero_dim", 32'(err_cnt), 32'd4);
        do_read("rd_s2_dims", 2'd2, 3'd2, 3'd3, 16'h00A5, 3'd3, 3'd4);
        // Write to a slot that was never given dims.
        el_write(2'd0, 3'd0, 3'd0, 16'h3333);
        check("err_invalid_slot", 32'(err_cnt), 32'd5);

        // ---------------- read-before-write ----------------
        dim_write(2'd1, 3'd2, 3'd2);
        rd_slot = 2'd1; rd_row = 3'd1; rd_col = 3'd1; rd_en = 1'b1;
        wr_slot = 2'd1; wr_row = 3'd1; wr_col = 3'd1; wr_data = 16'h0007;
        wr_we = 1'b1;
        sb.push_back('{data: 16'h0, m: 3'd2, n: 3'd2});
        tick();
        rd_en = 1'b0; wr_we = 1'b0;
        compare_read("rbw_old");
        do_read("rbw_new", 2'd1, 3'd1, 3'd1, 16'h0007, 3'd2, 3'd2);

        // ---------------- same-cycle dim + element write ----------------
        // Slot 2 is 3x4: element (0,3) fits the old dims, then dims shrink.
        err_cnt = 0;
        dim_slot = 2'd2; dim_m = 3'd1; dim_n = 3'd1; dim_we = 1'b1;
        wr_slot = 2'd2; wr_row = 3'd0; wr_col = 3'd3; wr_data = 16'hBEEF;
        wr_we = 1'b1;
        tick();
        dim_we = 1'b0; wr_we = 1'b0;
        check("same_cycle_no_err", 32'(err_cnt), 32'd0);
        dim_write(2'd2, 3'd3, 3'd4);
        do_read("same_cycle_data", 2'd2, 3'd0, 3'd3, 16'hBEEF, 3'd3, 3'd4);

        // ---------------- sweep clear ----------------
        dim_write(2'd1, 3'd5, 3'd5);
        dim_write(2'd3, 3'd2, 3'd2);
        for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
                el_write(2'd1, 3'(r), 3'(c), 16'(r * MAX_DIM + c + 1));
            end
        end
        do_read("fill_44", 2'd1, 3'd4, 3'd4, 16'd25, 3'd5, 3'd5);
        do_read("fill_23", 2'd1, 3'd2, 3'd3, 16'd14, 3'd5, 3'd5);

        err_cnt = 0;
        clr_slot = 2'd1; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("clr_valid_drop", 32'(slot_valid), 32'hC);
        check("clr_busy_start", 32'(clr_busy), 32'd1);
        busy_cnt = 1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 2) begin
                wr_slot = 2'd1; wr_row = 3'd0; wr_col = 3'd0;
                wr_data = 16'hFFFF; wr_we = 1'b1;
            end
            if (i == 3) begin
                wr_slot = 2'd3; wr_row = 3'd1; wr_col = 3'd1;
                wr_data = 16'h0033; wr_we = 1'b1;
            end
            if (i == 4) begin
                dim_slot = 2'd1; dim_m = 3'd2; dim_n = 3'd2; dim_we = 1'b1;
            end
            if (i == 5) begin
                clr_slot = 2'd3; clr_start = 1'b1;
            end
            tick();
            wr_we = 1'b0; dim_we = 1'b0; clr_start = 1'b0;
            if (clr_busy === 1'b1) busy_cnt++;
            if (clr_done === 1'b1) done_cnt++;
        end
        check("clr_busy_cycles", 32'(busy_cnt), 32'd25);
        check("clr_done_pulses", 32'(done_cnt), 32'd1);
        check("clr_busy_errs",   32'(err_cnt),  32'd2);
        check("clr_after_valid", 32'(slot_valid), 32'hC);

        do_read("clr_s1_invalid", 2'd1, 3'd2, 3'd2, 16'h0, 3'd0, 3'd0);
        do_read("clr_s3_write",   2'd3, 3'd1, 3'd1, 16'h0033, 3'd2, 3'd2);
        dim_write(2'd1, 3'd5, 3'd5);
        err_base = errors;
        for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
                do_read("clr_s1_zero", 2'd1, 3'(r), 3'(c), 16'h0, 3'd5, 3'd5);
            end
        end

        // ---------------- reset during sweep ----------------
        dim_write(2'd0, 3'd5, 3'd5);
        el_write(2'd0, 3'd0, 3'd0, 16'h0055);
        clr_slot = 2'd0; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (10) tick();
        check("mid_sweep_busy", 32'(clr_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_sweep_busy",  32'(clr_busy),   32'd0);
        check("rst_sweep_valid", 32'(slot_valid), 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clr_done === 1'b1) done_cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clr_done === 1'b1) done_cnt++;
        end
        check("rst_sweep_no_done", 32'(done_cnt), 32'd0);
        do_read("rst_s3_invalid", 2'd3, 3'd1, 3'd1, 16'h0, 3'd0, 3'd0);
        dim_write(2'd3, 3'd2, 3'd2);
        do_read("rst_s3_zero", 2'd3, 3'd1, 3'd1, 16'h0, 3'd2, 3'd2);
        dim_write(2'd1, 3'd5, 3'd5);
        do_read("rst_s1_zero", 2'd1, 3'd2, 3'd3, 16'h0, 3'd5, 3'd5);

        if (err_base < 0) $display("unreachable");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
